tick_dir_gen: RTL and testbench

- Generates the `i_valid` advance tick and the `i_reverse` direction level for the LED shift-register stage that sits directly downstream.
- The tick is a single-cycle pulse from a free-running prescaler counter; four rates are selectable from switches, and the switches can also freeze the counter.
- Direction is a level that toggles once per debounced press of a mechanical push-button.
- All outputs are registered.

---
 rtl/tick_dir_if.sv | 14 +
 rtl/tick_dir_gen.sv | 125 ++++++++++++
 tb/tb_tick_dir_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_dir_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_dir_if
// Brief    : Advance tick and direction level handed to the LED shift stage.
// Revision : 1.0
// ============================================================================
interface tick_dir_if;
   logic o_valid;
   logic o_reverse;

   modport master (output o_valid, output o_reverse);
   modport slave  (input  o_valid, input  o_reverse);
endinterface
`default_nettype wire

// File: rtl/tick_dir_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_dir_gen
// Brief    : Switch-selectable prescaler tick plus debounced push-button
//            direction toggle for the downstream LED shift stage.
// Revision : 1.0
// ============================================================================
module tick_dir_gen #(
   parameter int NB_COUNTER      = 32,
   parameter int NB_SW           = 3,
   parameter int NB_DEBOUNCE     = 20,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  wire              clock,
   input  wire              i_reset,
   input  wire [NB_SW-1:0]  i_sw,
   input  wire              i_btn,
   tick_dir_if.master       out_if
);

   localparam logic [NB_COUNTER-1:0] c_lim_0 = {{10{1'b0}}, {(NB_COUNTER-10){1'b1}}};
   localparam logic [NB_COUNTER-1:0] c_lim_1 = {{11{1'b0}}, {(NB_COUNTER-11){1'b1}}};
   localparam logic [NB_COUNTER-1:0] c_lim_2 = {{12{1'b0}}, {(NB_COUNTER-12){1'b1}}};
   localparam logic [NB_COUNTER-1:0] c_lim_3 = {{13{1'b0}}, {(NB_COUNTER-13){1'b1}}};

   localparam logic [NB_DEBOUNCE-1:0] c_db_last = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] c_idle         = 2'd0;
   localparam logic [1:0] c_press_wait   = 2'd1;
   localparam logic [1:0] c_held         = 2'd2;
   localparam logic [1:0] c_release_wait = 2'd3;

   logic [NB_COUNTER-1:0]  r_counter;
   logic [NB_COUNTER-1:0]  w_limit;
   logic                   r_valid;
   logic                   r_reverse;
   logic                   r_sync_1;
   logic                   r_btn_s;
   logic [NB_DEBOUNCE-1:0] r_dc;
   logic [1:0]             r_state;

   always_comb begin
      w_limit = c_lim_0;
      case (i_sw[2:1])
         2'b00:   w_limit = c_lim_0;
         2'b01:   w_limit = c_lim_1;
         2'b10:   w_limit = c_lim_2;
         default: w_limit = c_lim_3;
      endcase
   end

   // >= rather than == so a rate change below the current count wraps at once
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_counter <= '0;
         r_valid   <= 1'b0;
      end else if (!i_sw[0]) begin
         r_valid   <= 1'b0;
      end else if (r_counter >= w_limit) begin
         r_counter <= '0;
         r_valid   <= 1'b1;
      end else begin
         r_counter <= r_counter + 1'b1;
         r_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_sync_1 <= 1'b0;
         r_btn_s  <= 1'b0;
      end else begin
         r_sync_1 <= i_btn;
         r_btn_s  <= r_sync_1;
      end
   end

   // Direction flips only when a press has been stable long enough to enter HELD
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= c_idle;
         r_dc      <= '0;
         r_reverse <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (r_btn_s) begin
                  r_state <= c_press_wait;
                  r_dc    <= '0;
               end
            end
            c_press_wait: begin
               if (!r_btn_s) begin
                  r_state <= c_idle;
               end else if (r_dc == c_db_last) begin
                  r_state   <= c_held;
                  r_reverse <= ~r_reverse;
               end else begin
                  r_dc <= r_dc + 1'b1;
               end
            end
            c_held: begin
               if (!r_btn_s) begin
                  r_state <= c_release_wait;
                  r_dc    <= '0;
               end
            end
            default: begin
               if (r_btn_s) begin
                  r_state <= c_held;
               end else if (r_dc == c_db_last) begin
                  r_state <= c_idle;
               end else begin
                  r_dc <= r_dc + 1'b1;
               end
            end
         endcase
      end
   end

   assign out_if.o_valid   = r_valid;
   assign out_if.o_reverse = r_reverse;

endmodule
`default_nettype wire

// File: tb/tb_tick_dir_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_dir_gen
// Brief    : Randomized and directed scoreboard bench for tick_dir_gen.
// Revision : 1.0
// ============================================================================
module tb_tick_dir_gen;

   localparam int NB_COUNTER  = 14;
   localparam int NB_SW       = 3;
   localparam int NB_DEBOUNCE = 3;
   localparam int D           = 4;

   logic             clock = 1'b0;
   logic             i_reset = 1'b0;
   logic [NB_SW-1:0] i_sw = '0;
   logic             i_btn = 1'b0;

   tick_dir_if dut_if ();

   tick_dir_gen #(
      .NB_COUNTER      (NB_COUNTER),
      .NB_SW           (NB_SW),
      .NB_DEBOUNCE     (NB_DEBOUNCE),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw),
      .i_btn   (i_btn),
      .out_if  (dut_if)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   // Reference model: tick from a rate-limited count, direction from run lengths
   typedef struct packed { logic v; logic r; } exp_t;
   exp_t q[$];
   int   m_cnt, m_lim, hi_run, lo_run;
   bit   m_rev, m_b1, m_b2, m_bs, m_held, m_v;

   always @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         m_cnt = 0; m_rev = 0; m_b1 = 0; m_b2 = 0;
         hi_run = 0; lo_run = 0; m_held = 0;
         q.delete();
      end else begin
         m_bs = m_b2; m_b2 = m_b1; m_b1 = i_btn;
         m_lim = (1 << (NB_COUNTER - 10 - int'(i_sw[2:1]))) - 1;
         m_v = 0;
         if (i_sw[0]) begin
            if (m_cnt >= m_lim) begin m_cnt = 0; m_v = 1; end
            else m_cnt++;
         end
         if (!m_held) begin
            if (m_bs) begin
               hi_run++;
               if (hi_run == D + 1) begin m_rev = !m_rev; m_held = 1; lo_run = 0; end
            end else hi_run = 0;
         end else begin
            if (!m_bs) begin
               lo_run++;
               if (lo_run == D + 1) begin m_held = 0; hi_run = 0; end
            end else lo_run = 0;
         end
         q.push_back({m_v, m_rev});
      end
   end

   int   n_pulse = 0;
   int   n_rev_chg = 0;
   logic last_rev = 1'b0;
   exp_t e;

   always @(posedge clock) begin
      if (i_reset) begin
         #1;
         if (i_reset) begin
            if (q.size() == 0) begin
               chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("o_valid", 32'(dut_if.o_valid), 32'(e.v));
               chk("o_reverse", 32'(dut_if.o_reverse), 32'(e.r));
               if (dut_if.o_valid) n_pulse++;
               if (dut_if.o_reverse !== last_rev) n_rev_chg++;
               last_rev = dut_if.o_reverse;
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic btn_run(input logic lvl, input int n);
      i_btn = lvl;
      cycles(n);
   endtask

   task automatic wait_cnt(input int target, input string name);
      int budget = 200;
      while (m_cnt != target && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (budget == 0) chk(name, 32'(m_cnt), 32'(target));
   endtask

   task automatic async_reset();
      @(posedge clock);
      #3 i_reset = 1'b0;
      #1;
      chk("rst_valid", 32'(dut_if.o_valid), 32'd0);
      chk("rst_reverse", 32'(dut_if.o_reverse), 32'd0);
      chk("rst_counter", 32'(dut.r_counter), 32'd0);
      @(negedge clock);
      i_reset = 1'b1;
      last_rev = 1'b0;
   endtask

   task automatic press(input int hold, input int gap);
      btn_run(1'b1, hold);
      btn_run(1'b0, gap);
   endtask

   int p0, r0;

   initial begin
      #1;
      chk("init_valid", 32'(dut_if.o_valid), 32'd0);
      chk("init_reverse", 32'(dut_if.o_reverse), 32'd0);
      i_sw = 3'b001;
      @(negedge clock);
      i_reset = 1'b1;

      // 1: slowest rate, pulses at edges 16/32/48/64
      cycles(15);
      chk("t1_no_early_pulse", 32'(n_pulse), 32'd0);
      cycles(49);
      chk("t1_pulses", 32'(n_pulse), 32'd4);
      chk("t1_reverse", 32'(dut_if.o_reverse), 32'd0);

      // 2: shrink the limit below the count
      wait_cnt(10, "t2_wait");
      i_sw = 3'b111;
      cycles(1);
      chk("t2_wrap_pulse", 32'(dut_if.o_valid), 32'd1);
      p0 = n_pulse;
      cycles(8);
      chk("t2_fast_pulses", 32'(n_pulse - p0), 32'd4);

      // 3: freeze and resume
      i_sw = 3'b101;
      wait_cnt(2, "t3_wait");
      i_sw = 3'b100;
      p0 = n_pulse;
      cycles(20);
      chk("t3_frozen", 32'(n_pulse - p0), 32'd0);
      i_sw = 3'b101;
      cycles(1);
      chk("t3_resume_none", 32'(dut_if.o_valid), 32'd0);
      cycles(1);
      chk("t3_resume_pulse", 32'(dut_if.o_valid), 32'd1);

      // 4: bounce, clean press, bouncy release
      i_sw = 3'b000;
      r0 = n_rev_chg;
      btn_run(1'b1, 2); btn_run(1'b0, 3); btn_run(1'b1, 3); btn_run(1'b0, 8);
      chk("t4_bounce", 32'(dut_if.o_reverse), 32'd0);
      btn_run(1'b1, 6);
      chk("t4_before_edge7", 32'(dut_if.o_reverse), 32'd0);
      btn_run(1'b1, 1);
      chk("t4_edge7", 32'(dut_if.o_reverse), 32'd1);
      btn_run(1'b1, 5);
      btn_run(1'b0, 2); btn_run(1'b1, 1); btn_run(1'b0, 1); btn_run(1'b1, 2); btn_run(1'b0, 10);
      chk("t4_reverse", 32'(dut_if.o_reverse), 32'd1);
      chk("t4_one_toggle", 32'(n_rev_chg - r0), 32'd1);

      // 5: two clean presses from a fresh reset
      async_reset();
      press(10, 10);
      chk("t5_first", 32'(dut_if.o_reverse), 32'd1);
      press(10, 10);
      chk("t5_second", 32'(dut_if.o_reverse), 32'd0);

      // 6: reset mid-count with reverse set
      press(10, 10);
      i_sw = 3'b001;
      cycles(7);
      chk("t6_pre_reverse", 32'(dut_if.o_reverse), 32'd1);
      p0 = n_pulse;
      async_reset();
      cycles(15);
      chk("t6_no_early", 32'(n_pulse - p0), 32'd0);
      cycles(1);
      chk("t6_first_pulse", 32'(dut_if.o_valid), 32'd1);

      // Random switches and bouncing button against the model
      for (int it = 0; it < 80; it++) begin
         i_sw = 3'($urandom_range(0, 7));
         for (int k = 0; k < 4; k++)
            btn_run(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      end

      cycles(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
